// File: rtl/saradc_sequencer.sv
// SAR ADC sequencer: optional calibration, periodic conversions, 1/2/4/8-sample
// averaging and a valid/ready result register with sticky overrun/timeout flags.
module saradc_sequencer #(
    parameter int RES_W      = 10,
    parameter int PERIOD_W   = 16,
    parameter int TIMEOUT    = 64,
    parameter int CAL_CYCLES = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cfg_start,
    input  logic                cfg_stop,
    input  logic                cfg_cont,
    input  logic                cfg_cal_req,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [1:0]          cfg_avg_log2,
    input  logic                status_clr,
    input  logic                adc_valid,
    input  logic [RES_W-1:0]    adc_result,
    output logic                adc_en,
    output logic                adc_cal,
    output logic [RES_W-1:0]    res_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output logic                overrun,
    output logic                timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CAL  = 2'd1;
    localparam logic [1:0] S_CONV = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam int ACC_W = RES_W + 3;

    logic [1:0]          state_q, state_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [1:0]          avg_q, avg_d;
    logic [3:0]          samp_q, samp_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                done_q, done_d;
    logic                adc_valid_q;
    logic                adc_en_q, adc_en_d;
    logic                adc_cal_q, adc_cal_d;
    logic                busy_q, busy_d;
    logic [RES_W-1:0]    res_data_q, res_data_d;
    logic                res_valid_q, res_valid_d;
    logic                overrun_q, overrun_d;
    logic                timeout_q, timeout_d;

    logic                valid_rise;
    logic [PERIOD_W-1:0] per_inc;
    logic [ACC_W-1:0]    acc_sum;
    logic [3:0]          samp_inc;
    logic [3:0]          samp_need;
    logic                gap_elapsed;
    logic                push;
    logic                timeout_set;
    logic                overrun_set;

    assign valid_rise  = adc_valid & ~adc_valid_q;
    assign per_inc     = (&per_q) ? per_q : per_q + PERIOD_W'(1);
    assign acc_sum     = acc_q + ACC_W'(adc_result);
    assign samp_inc    = samp_q + 4'd1;
    assign samp_need   = 4'd1 << avg_q;
    // Widened compare so that cfg_period of 0 or 1 both mean a single gap cycle.
    assign gap_elapsed = ({1'b0, per_q} + {{PERIOD_W{1'b0}}, 1'b1}) >= {1'b0, cfg_period};

    always_comb begin
        // NOTE: every next-state variable gets a default here so no latch is inferred.
        state_d     = state_q;
        per_d       = per_q;
        avg_d       = avg_q;
        samp_d      = samp_q;
        acc_d       = acc_q;
        done_d      = done_q;
        push        = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_start && !cfg_stop) begin
                    avg_d   = cfg_avg_log2;
                    per_d   = '0;
                    samp_d  = '0;
                    acc_d   = '0;
                    done_d  = 1'b0;
                    state_d = cfg_cal_req ? S_CAL : S_CONV;
                end
            end
            S_CAL: begin
                per_d = per_inc;
                if (per_q == PERIOD_W'(CAL_CYCLES - 1)) begin
                    per_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                per_d = per_inc;
                if (valid_rise) begin
                    state_d = S_GAP;
                    if (samp_inc == samp_need) begin
                        push   = 1'b1;
                        acc_d  = '0;
                        samp_d = '0;
                        done_d = ~cfg_cont;
                    end else begin
                        acc_d  = acc_sum;
                        samp_d = samp_inc;
                    end
                end else if (per_q == PERIOD_W'(TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    state_d     = S_GAP;
                end
            end
            default: begin
                per_d = per_inc;
                if (done_q) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (gap_elapsed) begin
                    per_d   = '0;
                    state_d = S_CONV;
                end
            end
        endcase

        // Abort wins over anything the active state decided this cycle.
        if (cfg_stop && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            per_d       = '0;
            samp_d      = '0;
            acc_d       = '0;
            done_d      = 1'b0;
            push        = 1'b0;
            timeout_set = 1'b0;
        end

        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        overrun_set = 1'b0;
        if (push) begin
            res_data_d  = RES_W'(acc_sum >> avg_q);
            res_valid_d = 1'b1;
            overrun_set = res_valid_q & ~res_ready;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        overrun_d = overrun_set | (overrun_q & ~status_clr);
        timeout_d = timeout_set | (timeout_q & ~status_clr);
        adc_en_d  = (state_d == S_CONV);
        adc_cal_d = (state_d == S_CAL);
        busy_d    = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            per_q       <= '0;
            avg_q       <= '0;
            samp_q      <= '0;
            acc_q       <= '0;
            done_q      <= 1'b0;
            adc_valid_q <= 1'b0;
            adc_en_q    <= 1'b0;
            adc_cal_q   <= 1'b0;
            busy_q      <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_q       <= per_d;
            avg_q       <= avg_d;
            samp_q      <= samp_d;
            acc_q       <= acc_d;
            done_q      <= done_d;
            adc_valid_q <= adc_valid;
            adc_en_q    <= adc_en_d;
            adc_cal_q   <= adc_cal_d;
            busy_q      <= busy_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign adc_en    = adc_en_q;
    assign adc_cal   = adc_cal_q;
    assign busy      = busy_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;

endmodule
